// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: byte FIFO feeding an LSB-first UART serializer.
// The default build sends 8N1 frames of 10 bits.
// Define UART_TX_PARITY_EN to add a PARITY state after DATA that sends even
// parity (^byte), which gives an 11-bit frame.
// Each bit lasts CLK_FRE*1e6/BAUD_RATE cycles. A new frame starts right at the
// end of STOP whenever the FIFO still holds data.
module uart_tx_buffered #(
    parameter int CLK_FRE    = 27,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_data_valid,
    output logic                          tx_data_ready,
    output logic                          tx_pin,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CYCLES_PER_BIT = CLK_FRE * 1000000 / BAUD_RATE;
    localparam int CNT_W          = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
    localparam int PTR_W          = $clog2(FIFO_DEPTH);
    localparam int LVL_W          = PTR_W + 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               parity_q, parity_d;
    logic               tx_pin_q, tx_pin_d;
    logic               busy_q, busy_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [7:0]         head;
    logic               full, empty, push, pop, baud_end;

    // FIFO status and the head byte. The head is read asynchronously so that
    // the pop edge can load the shifter directly, which gives one-cycle latency.
    always_comb begin
        full     = (level_q == LVL_FULL);
        empty    = (level_q == '0);
        push     = tx_data_valid && !full;
        head     = mem[rd_ptr_q];
        baud_end = (baud_q == BAUD_LAST);
    end

    // FSM next state, serializer datapath, pop request and next line level.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        tx_pin_d  = tx_pin_q;
        pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_pin_d = 1'b1;
                if (!empty) begin
                    pop      = 1'b1;
                    state_d  = ST_START;
                    baud_d   = '0;
                    shift_d  = head;
                    parity_d = ^head;
                    tx_pin_d = 1'b0;
                end
            end
            ST_START: begin
                if (baud_end) begin
                    state_d   = ST_DATA;
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    tx_pin_d  = shift_q[0];
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d  = ST_PARITY;
                        tx_pin_d = parity_q;
`else
                        state_d  = ST_STOP;
                        tx_pin_d = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_pin_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_end) begin
                    state_d  = ST_STOP;
                    baud_d   = '0;
                    tx_pin_d = 1'b1;
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (!empty) begin
                        // Chain straight into the next frame with no idle gap.
                        pop      = 1'b1;
                        state_d  = ST_START;
                        shift_d  = head;
                        parity_d = ^head;
                        tx_pin_d = 1'b0;
                    end else begin
                        state_d  = ST_IDLE;
                        tx_pin_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + CNT_W'(1);
                end
            end
            default: begin
                state_d  = ST_IDLE;
                baud_d   = '0;
                tx_pin_d = 1'b1;
            end
        endcase
    end

    // FIFO pointers and level. Busy is derived from next-state values so
    // that the registered output needs no decode after the flops.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        busy_d = (state_d != ST_IDLE) || (level_d != '0);
    end

    // State registers. Reset aborts any frame and drives the line high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            parity_q  <= 1'b0;
            tx_pin_q  <= 1'b1;
            busy_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            tx_pin_q  <= tx_pin_d;
            busy_q    <= busy_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
        end
    end

    // FIFO storage write. The contents need no reset because the level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= tx_data;
        end
    end

    assign tx_data_ready = !full;
    assign tx_pin        = tx_pin_q;
    assign tx_busy       = busy_q;
    assign fifo_level    = level_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Testbench for uart_tx_buffered. A line receiver decodes the frames it sees on
// tx_pin into rx_q. Every accepted push adds the expected byte to exp_q, and
// each test compares the two queues in order.
// Build with UART_TX_PARITY_EN defined to cover the parity frame.
module tb_uart_tx_buffered;

    localparam int CLK_FRE = 27;
    localparam int BAUD    = 115200;
    localparam int DEPTH   = 16;
    localparam int CPB     = CLK_FRE * 1000000 / BAUD;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME = FB * CPB;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    tx_data = 8'd0;
    logic          tx_data_valid = 1'b0;
    logic          tx_data_ready;
    logic          tx_pin;
    logic          tx_busy;
    logic [LW-1:0] fifo_level;

    uart_tx_buffered #(.CLK_FRE(CLK_FRE), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_data_ready (tx_data_ready),
        .tx_pin        (tx_pin),
        .tx_busy       (tx_busy),
        .fifo_level    (fifo_level)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] data;
        logic       start_bit;
        logic       par;
        logic       stop_bit;
        longint     start_cyc;
    } rx_t;

    logic [7:0] exp_q[$];
    rx_t        rx_q[$];

    // Waits n cycles for the line receiver and flags any reset seen meanwhile.
    task automatic rx_wait(input int n, inout bit ab);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rst_n !== 1'b1) ab = 1'b1;
        end
    endtask

    // Line receiver. It samples at mid-bit and drops any frame that a reset cut short.
    initial begin : rx_proc
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_pin === 1'b0) begin
                rx_t r;
                bit  ab;
                ab          = 1'b0;
                r.start_cyc = cyc;
                r.par       = 1'b0;
                rx_wait(CPB / 2, ab);
                r.start_bit = tx_pin;
                for (int b = 0; b < 8; b++) begin
                    rx_wait(CPB, ab);
                    r.data[b] = tx_pin;
                end
`ifdef UART_TX_PARITY_EN
                rx_wait(CPB, ab);
                r.par = tx_pin;
`endif
                rx_wait(CPB, ab);
                r.stop_bit = tx_pin;
                if (!ab) rx_q.push_back(r);
            end
        end
    end

    // Offers one byte and waits, with a bound, until the DUT accepts it.
    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        tx_data       = b;
        tx_data_valid = 1'b1;
        while (tx_data_ready !== 1'b1 && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (tx_data_ready !== 1'b1) begin
            bad++;
            $display("FAIL push_wait: ready=%b after %0d cycles, required 1", tx_data_ready, n);
            tx_data_valid = 1'b0;
        end else begin
            @(posedge clk);
            exp_q.push_back(b);
            #1;
            tx_data_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total++; if (tx_pin !== 1'b1) begin bad++; $display("FAIL reset_pin: got=%b want=1", tx_pin); end
        total++; if (tx_data_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got=%b want=1", tx_data_ready); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got=%b want=0", tx_busy); end
        total++; if (fifo_level !== LW'(0)) begin bad++; $display("FAIL reset_level: got=%0d want=0", fifo_level); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        $display("reset: pin=%b ready=%b busy=%b level=%0d", tx_pin, tx_data_ready, tx_busy, fifo_level);
    endtask

    task automatic test_single();
        int n;
        push_byte(8'h55);
        total++; if (fifo_level !== LW'(1)) begin bad++; $display("FAIL single_level_push: got=%0d want=1", fifo_level); end
        total++; if (tx_busy !== 1'b1) begin bad++; $display("FAIL single_busy_push: got=%b want=1", tx_busy); end
        total++; if (tx_pin !== 1'b1) begin bad++; $display("FAIL single_pin_before_pop: got=%b want=1", tx_pin); end
        @(posedge clk);
        #1;
        total++; if (tx_pin !== 1'b0) begin bad++; $display("FAIL single_start_latency: got=%b want=0", tx_pin); end
        total++; if (fifo_level !== LW'(0)) begin bad++; $display("FAIL single_level_pop: got=%0d want=0", fifo_level); end
        n = 0;
        while (tx_busy === 1'b1 && n < FRAME + 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++; if (n != FRAME) begin bad++; $display("FAIL single_frame_len: got=%0d want=%0d", n, FRAME); end
        total++; if (tx_pin !== 1'b1) begin bad++; $display("FAIL single_idle_pin: got=%b want=1", tx_pin); end
        total++;
        if (rx_q.size() != 1) begin
            bad++;
            $display("FAIL single_rx_count: got=%0d want=1", rx_q.size());
        end else begin
            rx_t r;
            logic [7:0] e;
            r = rx_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (r.data !== e || r.start_bit !== 1'b0 || r.stop_bit !== 1'b1) begin
                bad++;
                $display("FAIL single_frame: got data=%h start=%b stop=%b want data=%h start=0 stop=1",
                         r.data, r.start_bit, r.stop_bit, e);
            end
`ifdef UART_TX_PARITY_EN
            total++; if (r.par !== ^e) begin bad++; $display("FAIL single_parity: got=%b want=%b", r.par, ^e); end
`endif
            $display("single: byte %h sent as %h, frame %0d cycles", e, r.data, n);
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int     n;
        longint st[3];
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'hA5);
        n = 0;
        while (rx_q.size() < 3 && n < 4 * FRAME) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (rx_q.size() != 3) begin
            bad++;
            $display("FAIL b2b_rx_count: got=%0d want=3", rx_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                rx_t r;
                logic [7:0] e;
                r = rx_q.pop_front();
                e = exp_q.pop_front();
                st[k] = r.start_cyc;
                total++;
                if (r.data !== e || r.start_bit !== 1'b0 || r.stop_bit !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_frame%0d: got data=%h start=%b stop=%b want data=%h", k, r.data, r.start_bit, r.stop_bit, e);
                end
`ifdef UART_TX_PARITY_EN
                total++; if (r.par !== ^e) begin bad++; $display("FAIL b2b_parity%0d: got=%b want=%b", k, r.par, ^e); end
`endif
                $display("b2b: frame %0d byte %h got %h start@%0d", k, e, r.data, r.start_cyc);
            end
            for (int k = 1; k < 3; k++) begin
                total++;
                if (st[k] - st[k-1] != longint'(FRAME)) begin
                    bad++;
                    $display("FAIL b2b_gap%0d: got=%0d want=%0d", k, st[k] - st[k-1], FRAME);
                end
            end
        end
        exp_q.delete();
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_full();
        int n;
        // The first byte stalls the serializer in its frame. The next sixteen bytes fill the FIFO.
        push_byte(8'h10);
        for (int i = 0; i < DEPTH; i++) push_byte(8'h20 + 8'(i));
        total++; if (fifo_level !== LW'(DEPTH)) begin bad++; $display("FAIL full_level: got=%0d want=%0d", fifo_level, DEPTH); end
        total++; if (tx_data_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got=%b want=0", tx_data_ready); end
        @(negedge clk);
        tx_data       = 8'hEE;
        tx_data_valid = 1'b1;
        repeat (20) @(negedge clk);
        total++; if (fifo_level !== LW'(DEPTH)) begin bad++; $display("FAIL full_hold_level: got=%0d want=%0d", fifo_level, DEPTH); end
        n = 0;
        while (tx_data_ready !== 1'b1 && n < FRAME + 10) begin
            @(negedge clk);
            n++;
        end
        total++; if (tx_data_ready !== 1'b1) begin bad++; $display("FAIL full_ready_return: got=%b want=1", tx_data_ready); end
        // Ready returns only after the pop edge, so the held byte has not been written yet.
        total++; if (fifo_level !== LW'(DEPTH - 1)) begin bad++; $display("FAIL full_pop_level: got=%0d want=%0d", fifo_level, DEPTH - 1); end
        @(posedge clk);
        exp_q.push_back(8'hEE);
        #1;
        tx_data_valid = 1'b0;
        total++; if (fifo_level !== LW'(DEPTH)) begin bad++; $display("FAIL full_refill_level: got=%0d want=%0d", fifo_level, DEPTH); end
        n = 0;
        while (rx_q.size() < DEPTH + 2 && n < (DEPTH + 3) * FRAME) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (rx_q.size() != DEPTH + 2) begin
            bad++;
            $display("FAIL full_rx_count: got=%0d want=%0d", rx_q.size(), DEPTH + 2);
        end else begin
            for (int k = 0; k < DEPTH + 2; k++) begin
                rx_t r;
                logic [7:0] e;
                r = rx_q.pop_front();
                e = exp_q.pop_front();
                total++;
                if (r.data !== e || r.stop_bit !== 1'b1) begin
                    bad++;
                    $display("FAIL full_frame%0d: got data=%h stop=%b want data=%h", k, r.data, r.stop_bit, e);
                end
                $display("full: frame %0d byte %h got %h", k, e, r.data);
            end
        end
        exp_q.delete();
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_simul();
        longint c0;
        push_byte(8'h61);
        c0 = cyc;
        for (int i = 0; i < 5; i++) push_byte(8'h62 + 8'(i));
        // The next pop edge is FRAME+1 edges after the accept edge of 0x61.
        while (cyc < c0 + longint'(FRAME)) @(negedge clk);
        total++; if (fifo_level !== LW'(5)) begin bad++; $display("FAIL simul_pre_level: got=%0d want=5", fifo_level); end
        tx_data       = 8'h67;
        tx_data_valid = 1'b1;
        @(posedge clk);
        #1;
        tx_data_valid = 1'b0;
        total++; if (fifo_level !== LW'(5)) begin bad++; $display("FAIL simul_level: got=%0d want=5", fifo_level); end
        total++; if (tx_pin !== 1'b0) begin bad++; $display("FAIL simul_next_start: got=%b want=0", tx_pin); end
        total++;
        if (rx_q.size() != 1) begin
            bad++;
            $display("FAIL simul_rx_count: got=%0d want=1", rx_q.size());
        end else begin
            rx_t r;
            r = rx_q.pop_front();
            total++; if (r.data !== 8'h61) begin bad++; $display("FAIL simul_frame: got=%h want=61", r.data); end
        end
        $display("simul: level %0d after push+pop edge", fifo_level);
    endtask

    task automatic test_reset_mid();
        int errs;
        // Clear what test_simul left queued and let the receiver finish its aborted frame.
        @(negedge clk);
        rst_n = 1'b0;
        repeat (FRAME) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        rx_q.delete();
        push_byte(8'h3C);
        push_byte(8'h11);
        // This point falls inside DATA bit 0 or 1 of 0x3C, where both bits are 0.
        repeat (CPB + CPB / 2) @(posedge clk);
        #2;
        total++; if (tx_pin !== 1'b0) begin bad++; $display("FAIL mid_pin_before: got=%b want=0", tx_pin); end
        rst_n = 1'b0;
        #1;
        total++; if (tx_pin !== 1'b1) begin bad++; $display("FAIL mid_rst_pin: got=%b want=1", tx_pin); end
        total++; if (fifo_level !== LW'(0)) begin bad++; $display("FAIL mid_rst_level: got=%0d want=0", fifo_level); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got=%b want=0", tx_busy); end
        total++; if (tx_data_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready: got=%b want=1", tx_data_ready); end
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        errs = 0;
        for (int i = 0; i < FRAME + CPB; i++) begin
            @(negedge clk);
            if (tx_pin !== 1'b1 || tx_busy !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL mid_idle_after: got=%0d non-idle cycles want=0", errs); end
        total++; if (rx_q.size() != 0) begin bad++; $display("FAIL mid_no_frame: got=%0d frames want=0", rx_q.size()); end
        $display("reset_mid: line idle after reset, %0d stray cycles", errs);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int n;
        push_byte(8'h07);
        push_byte(8'h03);
        n = 0;
        while (rx_q.size() < 2 && n < 3 * FRAME) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (rx_q.size() != 2) begin
            bad++;
            $display("FAIL parity_rx_count: got=%0d want=2", rx_q.size());
        end else begin
            rx_t r0;
            rx_t r1;
            r0 = rx_q.pop_front();
            r1 = rx_q.pop_front();
            total++; if (r0.data !== 8'h07 || r0.par !== 1'b1) begin bad++; $display("FAIL parity_07: got data=%h par=%b want data=07 par=1", r0.data, r0.par); end
            total++; if (r1.data !== 8'h03 || r1.par !== 1'b0) begin bad++; $display("FAIL parity_03: got data=%h par=%b want data=03 par=0", r1.data, r1.par); end
            $display("parity: 07 -> %b, 03 -> %b", r0.par, r1.par);
        end
        exp_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_simul();
        test_reset_mid();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
